// File: rtl/mac_vector_sequencer.sv
// Operand FIFO and vector sequencer in front of an external Q1.7 MAC: clears the
// accumulator per vector, streams one pair per cycle, and captures one result per vector.
module mac_vector_sequencer #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int MAC_LAT = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       mac_a,
  output logic [7:0]       mac_b,
  output logic             mac_clr,
  input  logic [7:0]       mac_o,
  output logic             res_valid,
  output logic [7:0]       res_data,
  input  logic             res_ready,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [7:0]       fifo_a [DEPTH];
  logic [7:0]       fifo_b [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [LEN_W-1:0] remaining;
  logic [DW-1:0]    drain_cnt;
  logic             clr_q;

  // Occupancy is judged before any same-cycle pop, so a full FIFO never takes a push.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready = !full && !RESET;
  assign push     = in_valid && in_ready;
  assign mac_clr  = clr_q || RESET;

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_a[wr_ptr[AW-1:0]] <= in_a;
      fifo_b[wr_ptr[AW-1:0]] <= in_b;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= next_state;
  end

  // Pops are decided here so the popped pair lands on mac_a/mac_b in the next cycle.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE:  if (start) next_state = CLEAR;
      CLEAR: begin
        next_state = (remaining == '0) ? DRAIN : RUN;
        pop        = (remaining != '0) && !empty;
      end
      RUN: begin
        if (remaining == '0) next_state = DRAIN;
        else                 pop        = !empty;
      end
      DRAIN: if (drain_cnt == '0) next_state = DONE;
      DONE:  if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    res_valid = (state == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      mac_a     <= '0;
      mac_b     <= '0;
      clr_q     <= 1'b0;
      remaining <= '0;
      drain_cnt <= '0;
      res_data  <= '0;
    end else begin
      mac_a <= pop ? fifo_a[rd_ptr[AW-1:0]] : 8'h00;
      mac_b <= pop ? fifo_b[rd_ptr[AW-1:0]] : 8'h00;
      clr_q <= (next_state == CLEAR);
      if (state == IDLE && start) remaining <= vec_len;
      else if (pop)               remaining <= remaining - 1'b1;
      if (next_state == DRAIN && state != DRAIN)     drain_cnt <= DW'(MAC_LAT - 1);
      else if (state == DRAIN && drain_cnt != '0)    drain_cnt <= drain_cnt - 1'b1;
      if (state == DRAIN && drain_cnt == '0) res_data <= mac_o;
    end
  end

endmodule

// File: tb/tb_mac_vector_sequencer.sv
// Bench for mac_vector_sequencer with a behavioural Q1.7 MAC (MAC_LAT=1) on the far side;
// expected results go into a scoreboard queue at start and are popped when res_valid rises.
module tb_mac_vector_sequencer;

  localparam int DEPTH   = 4;
  localparam int LEN_W   = 4;
  localparam int MAC_LAT = 1;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [7:0]       mac_a;
  logic [7:0]       mac_b;
  logic             mac_clr;
  logic [7:0]       mac_o;
  logic             res_valid;
  logic [7:0]       res_data;
  logic             res_ready;
  logic             busy;

  int         checks = 0;
  int         passes = 0;
  logic [7:0] sb[$];
  logic [7:0] obs_a[$];
  logic [7:0] obs_b[$];
  int         clr_count;
  int         rv_lat;
  bit         rv_to;
  logic [7:0] acc;

  mac_vector_sequencer #(.DEPTH(DEPTH), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_clr(mac_clr), .mac_o(mac_o),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Q1.7 x Q1.7 product truncated back to Q1.7
  function automatic logic [7:0] prod8(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p[14:7];
  endfunction

  always @(posedge CLK) begin
    if (mac_clr) acc <= 8'h00;
    else         acc <= acc + prod8(mac_a, mac_b);
  end
  assign mac_o = acc;

  task automatic push_pair(input logic [7:0] a, input logic [7:0] b);
    bit done = 0;
    in_valid = 1'b1; in_a = a; in_b = b;
    for (int i = 0; i < 20 && !done; i++) begin
      done = in_ready;
      @(negedge CLK);
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      $display("[TB] FAIL push_timeout: in_ready got 0 for 20 cycles, expected 1");
    end
  endtask

  task automatic run_vector(input logic [LEN_W-1:0] n);
    obs_a.delete(); obs_b.delete();
    clr_count = 0; rv_lat = 0; rv_to = 1;
    start = 1'b1; vec_len = n;
    @(negedge CLK);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      obs_a.push_back(mac_a); obs_b.push_back(mac_b);
      if (mac_clr) clr_count++;
      if (res_valid) begin rv_lat = c; rv_to = 0; break; end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; start = 0; vec_len = '0; in_valid = 0; in_a = 0; in_b = 0; res_ready = 1'b1;
    @(negedge CLK); @(negedge CLK);
    checks++; if (mac_clr !== 1'b1) $display("[TB] FAIL reset_clr: got %b expected 1", mac_clr); else passes++;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); else passes++;
    RESET = 1'b0;
    @(negedge CLK);
    checks++; if (mac_clr !== 1'b0) $display("[TB] FAIL post_reset_clr: got %b expected 0", mac_clr); else passes++;
    checks++; if ({mac_a, mac_b} !== 16'h0000) $display("[TB] FAIL reset_mac_ab: got %h expected 0000", {mac_a, mac_b}); else passes++;
    checks++; if (res_valid !== 1'b0) $display("[TB] FAIL reset_res_valid: got %b expected 0", res_valid); else passes++;
    checks++; if (res_data !== 8'h00) $display("[TB] FAIL reset_res_data: got %h expected 00", res_data); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); else passes++;
  endtask

  task automatic test_full_vector();
    logic [15:0] ep[3] = '{16'hC0C0, 16'hA0A0, 16'hC020};
    logic [7:0]  exp;
    for (int i = 0; i < 3; i++) push_pair(ep[i][15:8], ep[i][7:0]);
    sb.push_back(8'h58);
    run_vector(3);
    checks++; if (rv_to) $display("[TB] FAIL full_timeout: res_valid got 0 after 40 cycles, expected 1"); else passes++;
    checks++; if (rv_lat != 6) $display("[TB] FAIL full_latency: got %0d expected 6", rv_lat); else passes++;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({obs_a[k+1], obs_b[k+1]} !== ep[k])
        $display("[TB] FAIL full_operand%0d: got %h expected %h", k, {obs_a[k+1], obs_b[k+1]}, ep[k]);
      else passes++;
    end
    exp = sb.pop_front();
    checks++; if (res_data !== exp) $display("[TB] FAIL full_result: got %h expected %h", res_data, exp); else passes++;
    @(negedge CLK);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL full_idle: busy got %b expected 0", busy); else passes++;
  endtask

  task automatic test_backpressure();
    logic [7:0] ba[5] = '{8'h10, 8'h20, 8'h08, 8'hF0, 8'h30};
    logic [7:0] bb[5] = '{8'h10, 8'h20, 8'h40, 8'h10, 8'h30};
    logic [7:0] exp = 8'h00;
    bit ready_ok = 1, got = 0;
    int acc_cyc = -1, lat = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_a = ba[i]; in_b = bb[i];
      if (in_ready !== 1'b1) ready_ok = 0;
      @(negedge CLK);
    end
    in_a = ba[4]; in_b = bb[4];
    checks++; if (!ready_ok) $display("[TB] FAIL bp_first4: in_ready got 0, expected 1"); else passes++;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_full: in_ready got %b expected 0", in_ready); else passes++;
    for (int i = 0; i < 5; i++) exp = exp + prod8(ba[i], bb[i]);
    sb.push_back(exp);
    start = 1'b1; vec_len = 5;
    @(negedge CLK);
    start = 1'b0;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_full_clear: in_ready got %b expected 0", in_ready); else passes++;
    for (int c = 1; c <= 40; c++) begin
      if (res_valid) begin got = 1; lat = c; break; end
      if (in_valid && in_ready && acc_cyc < 0) acc_cyc = c;
      @(negedge CLK);
      if (acc_cyc >= 0) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    checks++; if (acc_cyc != 2) $display("[TB] FAIL bp_accept_cycle: got %0d expected 2", acc_cyc); else passes++;
    checks++; if (!got || lat != 8) $display("[TB] FAIL bp_latency: got %0d expected 8", lat); else passes++;
    exp = sb.pop_front();
    checks++; if (res_data !== exp) $display("[TB] FAIL bp_result: got %h expected %h", res_data, exp); else passes++;
    @(negedge CLK);
  endtask

  task automatic test_bubble();
    logic [7:0]  exp;
    logic [15:0] nz[$];
    push_pair(8'h40, 8'h40);
    sb.push_back(prod8(8'h40, 8'h40) + prod8(8'h20, 8'hE0));
    fork
      run_vector(2);
      begin repeat (3) @(negedge CLK); push_pair(8'h20, 8'hE0); end
    join
    checks++; if (rv_to) $display("[TB] FAIL bubble_timeout: res_valid got 0 after 40 cycles, expected 1"); else passes++;
    checks++; if ({obs_a[2], obs_b[2]} !== 16'h0000) $display("[TB] FAIL bubble_gap: got %h expected 0000", {obs_a[2], obs_b[2]}); else passes++;
    for (int i = 0; i < obs_a.size(); i++)
      if ({obs_a[i], obs_b[i]} != 16'h0000) nz.push_back({obs_a[i], obs_b[i]});
    checks++;
    if (nz.size() != 2 || nz[0] !== 16'h4040 || nz[1] !== 16'h20E0)
      $display("[TB] FAIL bubble_order: got %0d terms, expected 2 terms 4040,20E0", nz.size());
    else passes++;
    checks++; if (rv_lat != 7) $display("[TB] FAIL bubble_latency: got %0d expected 7", rv_lat); else passes++;
    exp = sb.pop_front();
    checks++; if (res_data !== exp) $display("[TB] FAIL bubble_result: got %h expected %h", res_data, exp); else passes++;
    @(negedge CLK);
  endtask

  task automatic test_zero_length();
    logic [7:0] exp;
    push_pair(8'h30, 8'h30);
    sb.push_back(8'h00);
    run_vector(0);
    checks++; if (rv_to || rv_lat != MAC_LAT + 2) $display("[TB] FAIL zero_latency: got %0d expected %0d", rv_lat, MAC_LAT + 2); else passes++;
    checks++; if (clr_count != 1) $display("[TB] FAIL zero_clr_pulses: got %0d expected 1", clr_count); else passes++;
    exp = sb.pop_front();
    checks++; if (res_data !== exp) $display("[TB] FAIL zero_result: got %h expected %h", res_data, exp); else passes++;
    @(negedge CLK);
    sb.push_back(prod8(8'h30, 8'h30));
    run_vector(1);
    exp = sb.pop_front();
    checks++; if (rv_to || res_data !== exp) $display("[TB] FAIL zero_fifo_kept: got %h expected %h", res_data, exp); else passes++;
    @(negedge CLK);
  endtask

  task automatic test_result_hold();
    logic [7:0] exp;
    push_pair(8'h50, 8'h50);
    sb.push_back(prod8(8'h50, 8'h50));
    res_ready = 1'b0;
    run_vector(1);
    exp = sb.pop_front();
    checks++; if (rv_to || res_data !== exp) $display("[TB] FAIL hold_result: got %h expected %h", res_data, exp); else passes++;
    for (int i = 0; i < 5; i++) begin
      start = (i == 1); vec_len = 2;
      @(negedge CLK);
      start = 1'b0;
      checks++;
      if (res_valid !== 1'b1 || res_data !== exp)
        $display("[TB] FAIL hold_cycle%0d: got valid=%b data=%h expected valid=1 data=%h", i, res_valid, res_data, exp);
      else passes++;
    end
    res_ready = 1'b1;
    @(negedge CLK);
    checks++; if (busy !== 1'b0 || res_valid !== 1'b0) $display("[TB] FAIL hold_release: got busy=%b valid=%b expected 0 0", busy, res_valid); else passes++;
    @(negedge CLK);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL hold_start_ignored: busy got %b expected 0", busy); else passes++;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] exp;
    push_pair(8'h10, 8'h10); push_pair(8'h20, 8'h20); push_pair(8'h30, 8'h30);
    start = 1'b1; vec_len = 3;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    checks++; if (mac_a !== 8'h10) $display("[TB] FAIL midrun_first: got %h expected 10", mac_a); else passes++;
    RESET = 1'b1;
    #1;
    checks++; if (mac_clr !== 1'b1) $display("[TB] FAIL midrun_clr: got %b expected 1", mac_clr); else passes++;
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL midrun_in_ready_rst: got %b expected 0", in_ready); else passes++;
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL midrun_idle: busy got %b expected 0", busy); else passes++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL midrun_in_ready: got %b expected 1", in_ready); else passes++;
    checks++; if (res_valid !== 1'b0) $display("[TB] FAIL midrun_res_valid: got %b expected 0", res_valid); else passes++;
    push_pair(8'h40, 8'h20);
    sb.push_back(prod8(8'h40, 8'h20));
    run_vector(1);
    exp = sb.pop_front();
    checks++; if (rv_to || res_data !== exp) $display("[TB] FAIL midrun_flushed: got %h expected %h", res_data, exp); else passes++;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_full_vector();
    test_backpressure();
    test_bubble();
    test_zero_length();
    test_result_hold();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mac_vector_sequencer.md
# mac_vector_sequencer

Upstream operand stage for the 8-bit Q1.7 MAC (`mactop`). It buffers signed operand pairs in a small FIFO and clears the MAC accumulator at the start of each dot-product vector. It then streams one pair per cycle into the MAC's A/B inputs and, once the MAC pipeline has drained, captures the MAC output as a single result with a valid/ready handshake. It drives the MAC's A, B and RESET pins directly and reads its O output.

## Interface
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- LEN_W, 4, width of vector-length field
- MAC_LAT, 1, cycles from operands on mac_a/mac_b to the result valid on mac_o
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- start  in  1  begin a vector; sampled only in IDLE
- vec_len  in  LEN_W  number of terms N, sampled with start
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO can accept the pair
- in_a, in_b  in  8  Q1.7 signed operands
- mac_a, mac_b  out  8  registered operands to MAC A/B
- mac_clr  out  1  registered; drives MAC RESET
- mac_o  in  8  MAC accumulator output
- res_valid  out  1  result available
- res_data  out  8  captured accumulator value
- res_ready  in  1  consumer accepts result
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - If start is high, latch N = vec_len and go to CLEAR.
  - A start pulse in any other state is ignored.
- CLEAR (1 cycle):
  - mac_clr=1, mac_a=mac_b=0.
  - Go to RUN if N>0; otherwise go to DRAIN.
- RUN:
  - If the FIFO is non-empty, pop a pair onto mac_a/mac_b and decrement the remaining count.
  - If the FIFO is empty, drive mac_a=mac_b=0. This is a bubble: it adds a zero product, so the sum is unaffected and the remaining count does not change.
  - After the last term is popped, go to DRAIN.
- DRAIN:
  - Lasts MAC_LAT cycles with mac_a=mac_b=0.
  - On its final cycle, capture mac_o into res_data. Go to DONE.
- DONE:
  - res_valid=1.
  - When res_ready is high, clear res_valid and go to IDLE.
- FIFO:
  - Pushes are accepted in every state, so operands for the next vector can be prefetched.
  - in_ready = !full && !RESET. in_ready is based on occupancy before any same-cycle pop: a full FIFO rejects a push even while it is popping.
  - When not full, a simultaneous push and pop leaves occupancy unchanged.
- Arithmetic: the sequencer does no arithmetic. mac_o passes unchanged into res_data, and overflow/wrap behaviour belongs to the MAC.
- Reset:
  - Outputs: mac_a=mac_b=0, res_data=0, res_valid=0, busy=0.
  - mac_clr is 1 while RESET is high and 0 on the first cycle after it.
  - The FIFO is flushed and the FSM returns to IDLE.
  - Reset mid-vector abandons the vector; no result is produced.

## Timing
- mac_a, mac_b and mac_clr are registered: they change one cycle after the state or pop decision.
- Operand k appears on mac_a/mac_b during cycle t_k. The MAC's sum including k is valid on mac_o during cycle t_k+MAC_LAT.
- res_data is captured at the end of cycle t_last+MAC_LAT. res_valid rises the following cycle.
- Minimum latency from start (FIFO pre-filled) to res_valid: 1 (CLEAR) + N + MAC_LAT + 1 cycles.
- With N=0, res_valid rises MAC_LAT+2 cycles after start, carrying the cleared accumulator value (0x00).
- res_valid and res_data stay stable until the cycle after res_ready is sampled high.

## Test plan
- Full vector:
  - Stimulus: pre-load (C0,C0), (A0,A0), (C0,20); start with N=3.
  - Required: mac_a/mac_b present C0, A0, C0 on consecutive cycles; res_data=0x58 (0.25+0.5625−0.125 with MAC truncation); res_valid at start+6.
- Backpressure (DEPTH=4):
  - Stimulus: push 5 pairs back-to-back in IDLE.
  - Required: in_ready drops after the 4th push; the 5th is accepted only after RUN pops one.
- Bubble:
  - Stimulus: start N=2 with one pair queued; supply the second pair 3 cycles later.
  - Required: mac_a=mac_b=0 during the gap; res_data equals the no-gap result.
- Zero length:
  - Stimulus: start with N=0.
  - Required: one mac_clr pulse; res_data=0x00; FIFO contents untouched.
- Result hold:
  - Stimulus: hold res_ready=0 for 5 cycles and pulse start meanwhile.
  - Required: res_valid and res_data stay stable; start is ignored; IDLE is reached one cycle after res_ready=1.
- Reset mid-RUN:
  - Stimulus: assert RESET for 1 cycle after 1 of 3 terms.
  - Required: next cycle IDLE; in_ready=1; FIFO empty; res_valid=0; mac_clr was high during reset.
